jtframe_dipcfg: RTL
===================

// Module: jtframe_dipcfg
// PURPOSE
//  Parametrised OSD status/DIP decoder with change qualification. It filters
//  multi-bit OSD status glitches, commits settings atomically and decodes
//  them into video, sound and core DIP controls. Video geometry changes get
//  a frame-counted mute window, and pause is aligned to vertical blank.
//  Sits between the OSD/HPS status word and the game core.
// PARAMETERS
//  SW          64    status word width (>= BANK_LSB+8*NBANK)
//  NBANK       2     number of 8-bit core DIP banks
//  BANK_LSB    24    status bit where core DIP banks start (must be >= 18)
//  STABLE      1024  cycles status must hold unchanged before commit (>=1)
//  MUTE_FRAMES 4     vblank periods vid_mute stays high after geometry change
//  ARX         4     native aspect X
//  ARY         3     native aspect Y
//  VERTICAL    0     1 = core may be vertical (core_mod[0] selects)
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous reset, active high
//  status       in   SW       raw OSD status word
//  core_mod     in   7        core mode; bit 0 = vertical game
//  game_pause   in   1        pause request from core/keyboard, active high
//  game_test    in   1        test request from core, active high
//  LVBL         in   1        vertical blank, active low, clk domain
//  hdmi_arx     out  13       HDMI aspect X
//  hdmi_ary     out  13       HDMI aspect Y
//  rotate       out  2        {flip, tate}
//  scanlines    out  3        scanline effect
//  dip_fxlevel  out  2        FX volume
//  dip_test     out  1        test DIP, active low
//  dip_pause    out  1        pause, active low
//  dips         out  8*NBANK  core DIP banks, active low
//  cfg_chg      out  1        one-cycle pulse on every commit
//  vid_mute     out  1        high while geometry settles
// BEHAVIOUR
//  Shadow register cfg[SW-1:0]; all decoded outputs derive from cfg only and are registered.
//  Reset: cfg=0, FSM=IDLE, counters=0, cfg_chg=0, vid_mute=0, dip_pause=1,
//   dip_test=1, dips=all 1s, rotate=0, scanlines=0, dip_fxlevel=2'b10,
//   hdmi_arx=ARX, hdmi_ary=ARY.
//  Geometry bits G = cfg[17:16] (ar), cfg[2] (no-rotate), cfg[1] (flip).
//  FSM:
//   IDLE:   if status!=cfg, latch sample<=status, cnt<=0 -> SETTLE.
//   SETTLE: if status!=sample, sample<=status, cnt<=0 (restart).
//           else cnt++; when cnt==STABLE-1 -> COMMIT.
//   COMMIT: cfg<=sample; cfg_chg=1 for this cycle; if G changed then
//           fcnt<=0, vid_mute<=1 -> MUTE, else -> IDLE.
//   MUTE:   count LVBL falling edges (LVBL_d & ~LVBL); at fcnt==MUTE_FRAMES-1
//           and an edge: vid_mute<=0 -> IDLE. Status changes here are not
//           sampled; they are caught in the next IDLE.
//  Commit latency: a stable change reaches outputs STABLE+3 cycles after it
//   first appears (IDLE detect, STABLE SETTLE, COMMIT, output register).
//  Decode, registered one cycle after cfg:
//   tate = VERTICAL & core_mod[0] & ~cfg[2]; rotate = {cfg[1], tate}
//   scanlines = cfg[5:3]; dip_fxlevel = 2'b10 ^ cfg[7:6]
//   dips = ~cfg[BANK_LSB +: 8*NBANK]; dip_test = ~(cfg[10] | game_test)
//   ar==0: {arx,ary} = tate ? {ARY,ARX} : {ARX,ARY}
//   ar!=0: hdmi_arx = {11'd0, ar-2'd1}, hdmi_ary = 0 (2-bit subtract, zero-extend)
//  Pause: req = game_pause | cfg[12]. dip_pause changes only on a LVBL
//   falling edge: it is set to ~req at that edge. A req pulse that sits
//   between two edges is lost.
//  An LVBL edge in the COMMIT cycle is not counted. fcnt saturates.
//  Reset in any state returns to the reset values above immediately.
// TESTING
//  1 Reset, status=0 -> dip_pause=1, dip_fxlevel=10, dips=FFFF, arx=4, ary=3, vid_mute=0.
//  2 status[7:6]=01 held -> dip_fxlevel=11 exactly STABLE+3 cycles later; one cfg_chg pulse.
//  3 Toggle status[4] every 100 cycles, STABLE=1024 -> no cfg_chg. Stop toggling -> one commit.
//  4 status[17:16]=10 -> arx=1, ary=0, vid_mute=1 for 4 LVBL falls, then 0.
//  5 VERTICAL=1, core_mod[0]=1, ar=0 -> rotate=01, arx=3, ary=4. Set status[2] -> rotate=00, arx=4, ary=3.
//  6 game_pause=1 mid-frame -> dip_pause stays 1 until next LVBL fall, then 0. Reset asserted during MUTE -> vid_mute=0 at once.

Source files
------------

// File: rtl/jtframe_dipcfg.sv
// jtframe_dipcfg: qualifies the OSD status word, commits it atomically to a shadow
// register and decodes it into video, sound and core DIP controls.
module jtframe_dipcfg #(
    parameter int SW          = 64,
    parameter int NBANK       = 2,
    parameter int BANK_LSB    = 24,
    parameter int STABLE      = 1024,
    parameter int MUTE_FRAMES = 4,
    parameter int ARX         = 4,
    parameter int ARY         = 3,
    parameter int VERTICAL    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SW-1:0]      status,
    input  logic [6:0]         core_mod,
    input  logic               game_pause,
    input  logic               game_test,
    input  logic               LVBL,
    output logic [12:0]        hdmi_arx,
    output logic [12:0]        hdmi_ary,
    output logic [1:0]         rotate,
    output logic [2:0]         scanlines,
    output logic [1:0]         dip_fxlevel,
    output logic               dip_test,
    output logic               dip_pause,
    output logic [8*NBANK-1:0] dips,
    output logic               cfg_chg,
    output logic               vid_mute
);
    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam int FW = (MUTE_FRAMES > 1) ? $clog2(MUTE_FRAMES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, MUTE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   cfg_q, cfg_d;
    logic [SW-1:0]   sample_q, sample_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            vid_mute_q, vid_mute_d;
    logic            lvbl_q;
    logic            lvbl_fall;
    logic            geom_chg;
    logic            tate;
    logic [1:0]      ar;
    logic [12:0]     arx_d, ary_d;
    logic            unused_bits;

    assign lvbl_fall   = lvbl_q & ~LVBL;
    assign geom_chg    = {sample_q[17:16], sample_q[2:1]} != {cfg_q[17:16], cfg_q[2:1]};
    assign ar          = cfg_q[17:16];
    assign tate        = (VERTICAL != 0) & core_mod[0] & ~cfg_q[2];
    assign unused_bits = ^{core_mod[6:1], cfg_q};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            sample_q   <= '0;
            cnt_q      <= '0;
            fcnt_q     <= '0;
            vid_mute_q <= 1'b0;
            lvbl_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            sample_q   <= sample_d;
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            vid_mute_q <= vid_mute_d;
            lvbl_q     <= LVBL;
        end
    end

    // NOTE: every signal gets a hold default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        sample_d   = sample_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        vid_mute_d = vid_mute_q;
        unique case (state_q)
            IDLE: if (status != cfg_q) begin
                sample_d = status;
                cnt_d    = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (status != sample_q) begin
                    sample_d = status;
                    cnt_d    = '0;
                end else if (cnt_q == CW'(STABLE - 1)) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                cfg_d = sample_q;
                if (geom_chg) begin
                    fcnt_d     = '0;
                    vid_mute_d = 1'b1;
                    state_d    = MUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            // Status is ignored while muted; a pending change is picked up back in IDLE.
            MUTE: if (lvbl_fall) begin
                if (fcnt_q == FW'(MUTE_FRAMES - 1)) begin
                    vid_mute_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        cfg_chg  = (state_q == COMMIT);
        vid_mute = vid_mute_q;
    end

    always_comb begin
        if (ar == 2'd0) begin
            arx_d = tate ? 13'(ARY) : 13'(ARX);
            ary_d = tate ? 13'(ARX) : 13'(ARY);
        end else begin
            arx_d = {11'd0, ar - 2'd1};
            ary_d = '0;
        end
    end

    // Decoded controls follow cfg_q one cycle later; pause only moves at vblank start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdmi_arx    <= 13'(ARX);
            hdmi_ary    <= 13'(ARY);
            rotate      <= 2'b00;
            scanlines   <= 3'd0;
            dip_fxlevel <= 2'b10;
            dip_test    <= 1'b1;
            dip_pause   <= 1'b1;
            dips        <= '1;
        end else begin
            hdmi_arx    <= arx_d;
            hdmi_ary    <= ary_d;
            rotate      <= {cfg_q[1], tate};
            scanlines   <= cfg_q[5:3];
            dip_fxlevel <= 2'b10 ^ cfg_q[7:6];
            dip_test    <= ~(cfg_q[10] | game_test);
            dips        <= ~cfg_q[BANK_LSB +: 8*NBANK];
            if (lvbl_fall) dip_pause <= ~(game_pause | cfg_q[12]);
        end
    end
endmodule
